// File: rtl/demorgan_sweep_checker_pkg.sv
// Shared types and constants for the De Morgan exhaustive sweep checker.
// Holds the sweep FSM state enumeration and the default operand width.
package demorgan_sweep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 2;

endpackage

// File: rtl/demorgan_nbit.sv
// Per-bit gate network: both sides of each De Morgan identity, computed
// independently so that the top level can compare them.
module demorgan_nbit
    import demorgan_sweep_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] p1,
    output logic [WIDTH-1:0] p2
);

    assign o1 = ~A & ~B;
    assign o2 = ~(A | B);
    assign p1 = ~(A & B);
    assign p2 = ~A | ~B;

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Exhaustive sweep of all A/B operand pairs through the De Morgan gate network,
// counting failing pairs. Optional macro FAULT_INJECT_EN adds a fault_inj port.
module demorgan_sweep_checker
    import demorgan_sweep_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH-1:0]   cur_a,
    output logic [WIDTH-1:0]   cur_b,
    output logic [2*WIDTH:0]   mismatch_cnt
`ifdef FAULT_INJECT_EN
    ,
    input  logic               fault_inj
`endif
);

    localparam logic [2*WIDTH-1:0] IDX_MAX = '1;
    localparam logic [2*WIDTH-1:0] IDX_ONE = 1;
    localparam logic [2*WIDTH:0]   CNT_ONE = 1;

    state_t              state;
    logic [2*WIDTH-1:0]  idx;
    logic [WIDTH-1:0]    o1, o2, p1, p2;
    logic [WIDTH-1:0]    o2_chk;
    logic                pair_fail;

    assign cur_a = idx[2*WIDTH-1:WIDTH];
    assign cur_b = idx[WIDTH-1:0];

    demorgan_nbit #(.WIDTH(WIDTH)) u_gates (
        .A  (cur_a),
        .B  (cur_b),
        .o1 (o1),
        .o2 (o2),
        .p1 (p1),
        .p2 (p2)
    );

    // The injected fault flips only bit 0 of the NOR side, enough to make every pair fail.
    always_comb begin
        o2_chk = o2;
`ifdef FAULT_INJECT_EN
        o2_chk[0] = o2[0] ^ fault_inj;
`endif
    end

    assign pair_fail = (o1 != o2_chk) || (p1 != p2);
    assign pass      = done && (mismatch_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            mismatch_cnt <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= SWEEP;
                        idx          <= '0;
                        mismatch_cnt <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (pair_fail) begin
                        mismatch_cnt <= mismatch_cnt + CNT_ONE;
                    end
                    // idx is left at zero outside SWEEP so cur_a/cur_b read zero there.
                    if (idx == IDX_MAX) begin
                        state <= DONE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
